wb_sched: RTL
=============

# wb_sched

Writeback scheduler for the SEQ/pipelined Y86-64 core. It accepts one retiring instruction per valid/ready handshake and decodes its destination registers. It then drives the register file's single write port, serialising the two writes of `popq` and suppressing `RNONE` writes. It sits between the memory stage and the 15-entry register file, replacing direct multi-port writes.

## Interface

**Parameters**
- `NREG`, default 15: number of architectural registers.
- `RNONE`, default 4'hF: "no register" index; writes to it are dropped.
- `RSP`, default 4'h4: stack pointer index.

**Ports**
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: command present.
- `in_ready`, out, 1: scheduler can accept a command this cycle.
- `icode`, in, 4: instruction code.
- `rA`, in, 4: register field A.
- `rB`, in, 4: register field B.
- `valE`, in, 64: ALU result.
- `valM`, in, 64: memory result.
- `wr_en`, out, 1: register-file write strobe.
- `wr_addr`, out, 4: write index, always < `NREG` when `wr_en` is high.
- `wr_data`, out, 64: write data.
- `cmd_done`, out, 1: one-cycle pulse in the cycle the command's last write (or empty slot) issues.
- `err_icode`, out, 1: one-cycle pulse; accepted `icode` > 11 was discarded.
- `busy_mask`, out, 15: only present with `WB_SCHED_SCOREBOARD_EN`.

## Operation

**Decode** (dstE/srcE = valE, dstM/srcM = valM):
- `icode` 2, 3, 6: dstE=`rB`.
- `icode` 5: dstM=`rA`.
- `icode` 8, 9, 10: dstE=`RSP`.
- `icode` 11: dstE=`RSP`, dstM=`rA`.
- `icode` 0, 1, 4, 7: no writes.
- Any dst equal to `RNONE` is removed.

**Handshake:**
- A command is accepted on a rising edge when `in_valid && in_ready`.
- Inputs are latched at accept and may change afterwards.

**FSM states:** `IDLE`, `WR_E`, `WR_M`, `EMPTY`.
- `IDLE` → `WR_E` on accept if dstE is valid.
- `IDLE` → `WR_M` on accept if only dstM is valid.
- `IDLE` → `EMPTY` on accept if there are no writes or `icode` is invalid.
- `WR_E` issues `wr_en`, addr=dstE, data=valE.
  - Goes to `WR_M` if dstM is pending.
  - Otherwise the command retires.
- `WR_M` issues addr=dstM, data=valM, then the command retires.
- `EMPTY` issues no write, then the command retires.
- On retire: `cmd_done`=1. If a new command is accepted in the same cycle, go straight to its first state; otherwise go to `IDLE`.

**`in_ready` rule:**
- High in `IDLE`.
- High in the final state of the current command, i.e. `WR_E` with no dstM, `WR_M`, or `EMPTY`.
- Low in `WR_E` when a `WR_M` follows.

**Ordering rules:**
- `popq %rsp` (rA=4): the E write precedes the M write, so RSP ends with valM.
- `popq` with rA=`RNONE` degenerates to a single E write.

**Invalid `icode`:**
- The command is accepted and goes through `EMPTY`.
- `err_icode` pulses together with `cmd_done`.

**Reset:**
- Forces `IDLE` and clears latched dst fields to `RNONE`.
- Any in-flight `WR_M` is abandoned with no further write.
- During reset `in_ready`=0; it is high in the first cycle after reset.

## Timing

- Reset values: `in_ready`=0 (while `Rst` is high), `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cmd_done`=0, `err_icode`=0, `busy_mask`=0.
- All outputs are registered-state decodes. `wr_*` are valid in the cycle after accept; the register file captures them on the next rising edge.
- Latency: accept at edge N gives the first write in cycle N+1, and the second write (popq) in cycle N+2.
- Throughput: 1 command/cycle for zero- or one-write commands; 1 per 2 cycles for two-write commands.
- `in_valid` with `in_ready` low has no effect; the sender holds the command.

## Configuration

- `WB_SCHED_SCOREBOARD_EN` defined:
  - `busy_mask` exists. Bit r is set from the accept edge until the edge that completes the final write to r.
  - Consumed by hazard logic. Bits for `RNONE`/no-write commands stay 0.
- Undefined: the `busy_mask` port and its logic are absent; all other behaviour is identical.

## Structure

- Shared package `wb_sched_pkg` holds:
  - icode constants (`I_HALT`..`I_POPQ`), `RNONE`, `RSP`;
  - the state enum `wb_state_t` with `IDLE`/`WR_E`/`WR_M`/`EMPTY`.
- One sub-module, `wb_dst_decode`: a combinational icode/rA/rB → dstE, dstM, valid, `bad_icode` decoder, reused by hazard logic.

## Test plan

- Reset, then `irmovq` (icode 3, rB=2, valE=0x55) → one cycle later `wr_en`=1, `wr_addr`=2, `wr_data`=0x55, `cmd_done`=1.
- `popq` (icode 11, rA=3, valE=0x108, valM=0xAB) → cycle 1: addr 4 / 0x108; cycle 2: addr 3 / 0xAB with `cmd_done`; `in_ready`=0 in cycle 1.
- `popq %rsp` (rA=4, valE=0x108, valM=0x77) → two writes to addr 4, with 0x77 last.
- Back-to-back `OPq` (rB=1), `nop`, `rmmovq`, `OPq` (rB=5) with `in_valid` held → 4 `cmd_done` pulses on consecutive cycles; writes only to 1 and 5.
- icode 0xC → no `wr_en`; `err_icode` and `cmd_done` pulse together.
- `Rst` asserted in the first write cycle of `popq` → no `WR_M` write; all outputs zero; `busy_mask`=0 (scoreboard build).

Source files
------------

// File: rtl/wb_sched_pkg.sv
// -----------------------------------------------------------------------------
// wb_sched_pkg
// Shared definitions for the Y86-64 writeback scheduler and any hazard logic
// that reuses its destination decoder.
//   - icode constants I_HALT .. I_POPQ
//   - register index constants RNONE ("no register") and RSP (stack pointer)
//   - wb_state_t : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package wb_sched_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_E  = 2'd1,
    WR_M  = 2'd2,
    EMPTY = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// -----------------------------------------------------------------------------
// wb_dst_decode
// Combinational destination decoder: icode/rA/rB -> dstE, dstM.
// A destination that is RNONE (or not a real register) is reported as RNONE
// with its valid flag low, so callers never see an unusable index.
// Ports:
//   i_icode, i_ra, i_rb : instruction fields
//   o_dst_e, o_e_valid  : E-port destination (written with valE)
//   o_dst_m, o_m_valid  : M-port destination (written with valM)
//   o_bad_icode         : icode above I_POPQ
// -----------------------------------------------------------------------------
module wb_dst_decode
  import wb_sched_pkg::*;
#(
  parameter int         NREG  = 15,
  parameter logic [3:0] RNONE = wb_sched_pkg::RNONE,
  parameter logic [3:0] RSP   = wb_sched_pkg::RSP
) (
  input  logic [3:0] i_icode,
  input  logic [3:0] i_ra,
  input  logic [3:0] i_rb,
  output logic [3:0] o_dst_e,
  output logic [3:0] o_dst_m,
  output logic       o_e_valid,
  output logic       o_m_valid,
  output logic       o_bad_icode
);

  logic [3:0] w_raw_e;
  logic [3:0] w_raw_m;

  always_comb begin
    w_raw_e     = RNONE;
    w_raw_m     = RNONE;
    o_bad_icode = 1'b0;
    case (i_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ: w_raw_e = i_rb;
      I_MRMOVQ:                  w_raw_m = i_ra;
      I_CALL, I_RET, I_PUSHQ:    w_raw_e = RSP;
      I_POPQ: begin
        w_raw_e = RSP;
        w_raw_m = i_ra;
      end
      I_HALT, I_NOP, I_RMMOVQ, I_JXX: ;
      default:                   o_bad_icode = 1'b1;
    endcase
  end

  // Range check keeps wr_addr < NREG even if RNONE is parameterised differently.
  assign o_e_valid = (w_raw_e != RNONE) && (int'(w_raw_e) < NREG);
  assign o_m_valid = (w_raw_m != RNONE) && (int'(w_raw_m) < NREG);
  assign o_dst_e   = o_e_valid ? w_raw_e : RNONE;
  assign o_dst_m   = o_m_valid ? w_raw_m : RNONE;

endmodule

// File: rtl/wb_sched.sv
// -----------------------------------------------------------------------------
// wb_sched
// Writeback scheduler for the Y86-64 core. Accepts one retiring instruction per
// in_valid/in_ready handshake, decodes its destinations and drives the single
// register-file write port, serialising the two writes of popq (E then M, so
// popq %rsp leaves RSP = valM) and dropping RNONE writes.
//
// Ports:
//   Clk, Rst          : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready : command handshake
//   icode, rA, rB     : instruction fields, latched at accept
//   valE, valM        : ALU / memory results, latched at accept
//   wr_en/addr/data   : register-file write port
//   cmd_done          : pulse when a command's last write (or empty slot) issues
//   err_icode         : pulse with cmd_done when the command's icode was invalid
//   busy_mask         : per-register pending-write mask
//                       (present only when WB_SCHED_SCOREBOARD_EN is defined)
//
// All outputs except in_ready are pure decodes of registered state.
// -----------------------------------------------------------------------------
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int         NREG  = 15,
  parameter logic [3:0] RNONE = wb_sched_pkg::RNONE,
  parameter logic [3:0] RSP   = wb_sched_pkg::RSP
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      icode,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic [63:0]     valE,
  input  logic [63:0]     valM,
  output logic            wr_en,
  output logic [3:0]      wr_addr,
  output logic [63:0]     wr_data,
  output logic            cmd_done,
  output logic            err_icode
`ifdef WB_SCHED_SCOREBOARD_EN
  ,
  output logic [NREG-1:0] busy_mask
`endif
);

  wb_state_t   r_state;
  wb_state_t   w_next;
  wb_state_t   w_first;
  logic [3:0]  r_dst_e;
  logic [3:0]  r_dst_m;
  logic        r_bad;
  logic [63:0] r_val_e;
  logic [63:0] r_val_m;

  logic [3:0]  w_dec_dst_e;
  logic [3:0]  w_dec_dst_m;
  logic        w_dec_e_valid;
  logic        w_dec_m_valid;
  logic        w_dec_bad;
  logic        w_m_pend;
  logic        w_last;
  logic        w_accept;

  wb_dst_decode #(
    .NREG  (NREG),
    .RNONE (RNONE),
    .RSP   (RSP)
  ) u_dec (
    .i_icode     (icode),
    .i_ra        (rA),
    .i_rb        (rB),
    .o_dst_e     (w_dec_dst_e),
    .o_dst_m     (w_dec_dst_m),
    .o_e_valid   (w_dec_e_valid),
    .o_m_valid   (w_dec_m_valid),
    .o_bad_icode (w_dec_bad)
  );

  // Handshake: ready in IDLE and in the last cycle of the current command so
  // single-slot commands stream at one per cycle.
  always_comb begin
    w_m_pend = (r_dst_m != RNONE);
    w_last   = ((r_state == WR_E) && !w_m_pend) ||
               (r_state == WR_M) || (r_state == EMPTY);
    in_ready = !Rst && ((r_state == IDLE) || w_last);
    w_accept = in_valid && in_ready;
  end

  // First state of the command being accepted this cycle.
  always_comb begin
    w_first = EMPTY;
    if (w_dec_bad)          w_first = EMPTY;
    else if (w_dec_e_valid) w_first = WR_E;
    else if (w_dec_m_valid) w_first = WR_M;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = w_accept ? w_first : IDLE;
      WR_E: begin
        if (w_m_pend) w_next = WR_M;
        else          w_next = w_accept ? w_first : IDLE;
      end
      WR_M, EMPTY: w_next = w_accept ? w_first : IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = 4'h0;
    wr_data   = 64'h0;
    cmd_done  = 1'b0;
    err_icode = 1'b0;
    case (r_state)
      WR_E: begin
        wr_en    = 1'b1;
        wr_addr  = r_dst_e;
        wr_data  = r_val_e;
        cmd_done = !w_m_pend;
      end
      WR_M: begin
        wr_en    = 1'b1;
        wr_addr  = r_dst_m;
        wr_data  = r_val_m;
        cmd_done = 1'b1;
      end
      EMPTY: begin
        cmd_done  = 1'b1;
        err_icode = r_bad;
      end
      default: ;
    endcase
  end

  // Control state: reset abandons any pending M write by clearing dstM.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_dst_e <= RNONE;
      r_dst_m <= RNONE;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dst_e <= w_dec_dst_e;
        r_dst_m <= w_dec_dst_m;
        r_bad   <= w_dec_bad;
      end
    end
  end

  // Data payload: only observable while a write state is active, so no reset.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_val_e <= valE;
      r_val_m <= valM;
    end
  end

`ifdef WB_SCHED_SCOREBOARD_EN
  // Only one command is ever in flight, so the pending set is exactly the
  // destinations not yet written by the current state. In WR_E with a pending
  // M write both bits stay set (popq %rsp keeps RSP busy until the M write).
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_state == WR_E)
        busy_mask[i] = (int'(r_dst_e) == i) || (w_m_pend && (int'(r_dst_m) == i));
      else if (r_state == WR_M)
        busy_mask[i] = (int'(r_dst_m) == i);
    end
  end
`endif

endmodule
